// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: state encoding and default widths.
package sdram_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/sdram_arbiter_rr_pick2.sv
// Two-way chooser: fixed priority to port 0, or round-robin against the last owner.
module rr_pick2
  import sdram_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       fixed_prio_i,
  output logic       grant_o
);
  always_comb begin
    grant_o = 1'b0;
    // On a tie in round-robin mode the port that did not go last wins.
    if (!fixed_prio_i && req_i == 2'b11) begin
      grant_o = ~last_i;
    end else begin
      grant_o = ~req_i[0];
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller command port between video (port 0) and CPU (port 1),
// one transaction in flight, with a read-data timeout.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ack,
  output logic              p0_valid,
  output logic [DATA_W-1:0] p0_q,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ack,
  output logic              p1_valid,
  output logic [DATA_W-1:0] p1_q,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_q,
  output logic              timeout_err,
  output logic              busy
);
  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic              p0_valid_q, p0_valid_d;
  logic              p1_valid_q, p1_valid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              grant;

  rr_pick2 u_pick (
    .req_i        ({p1_req, p0_req}),
    .last_i       (last_q),
    .fixed_prio_i (FIXED_PRIO != 0),
    .grant_o      (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    cnt_d      = cnt_q;
    terr_d     = terr_q;
    p0_valid_d = 1'b0;
    p1_valid_d = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p0_req || p1_req) begin
          owner_d    = grant;
          mem_req_d  = 1'b1;
          mem_we_d   = grant ? p1_we   : p0_we;
          mem_addr_d = grant ? p1_addr : p0_addr;
          mem_data_d = grant ? p1_data : p0_data;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          last_d    = owner_q;
          cnt_d     = 8'd0;
          state_d   = mem_we_q ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Data arriving on the final count still wins over the timeout.
        if (mem_valid) begin
          if (owner_q) begin
            p1_valid_d = 1'b1;
            p1_rdata_d = mem_q;
          end else begin
            p0_valid_d = 1'b1;
            p0_rdata_d = mem_q;
          end
          state_d = ST_IDLE;
        end else if (cnt_q == TO_CNT) begin
          terr_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cnt_q      <= 8'd0;
      terr_q     <= 1'b0;
      p0_valid_q <= 1'b0;
      p1_valid_q <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cnt_q      <= cnt_d;
      terr_q     <= terr_d;
      p0_valid_q <= p0_valid_d;
      p1_valid_q <= p1_valid_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // The ack is combinational so the requester sees it in the controller's accept cycle.
  assign p0_ack      = mem_ack & (state_q == ST_ISSUE) & ~owner_q;
  assign p1_ack      = mem_ack & (state_q == ST_ISSUE) & owner_q;
  assign p0_valid    = p0_valid_q;
  assign p1_valid    = p1_valid_q;
  assign p0_q        = p0_rdata_q;
  assign p1_q        = p1_rdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign timeout_err = terr_q;
  assign busy        = (state_q != ST_IDLE);
endmodule
